// File: rtl/de_pair_gen_pkg.sv
// Shared constants for the D/E operand-pair generator: operand width and
// controller state encodings.
package de_pair_gen_pkg;

    localparam int DE_W = 4;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_EMIT = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/de_pair_gen_datapath.sv
// Datapath for de_pair_gen: F/D registers, D incrementer, ripple subtractor
// Eo = F_reg - D_reg, and the end-of-run comparator. Honours DE_PAIR_WRAP_EN.
import de_pair_gen_pkg::*;

module de_pair_gen_datapath (
    input  logic            clk,
    input  logic            rst,
    input  logic [DE_W-1:0] F,
    input  logic            F_ld,
    input  logic            D_clr,
    input  logic            D_inc,
    output logic [DE_W-1:0] Do,
    output logic [DE_W-1:0] Eo,
    output logic            D_eq_last
);

    logic [DE_W-1:0] F_reg;
    logic [DE_W-1:0] D_reg;
    logic [DE_W-1:0] D_n;
    logic [DE_W-1:0] last;
    logic [DE_W-1:0] diff;
    logic [DE_W-1:0] carry;

    // NOTE: registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of the order the statements appear in.
    always_ff @(posedge clk) begin
        if (rst) begin
            F_reg <= '0;
            D_reg <= '0;
        end else begin
            if (F_ld)
                F_reg <= F;
            if (D_clr)
                D_reg <= '0;
            else if (D_inc)
                D_reg <= D_reg + 4'd1;
        end
    end

    // F + ~D + 1, carry-in of one, final borrow dropped.
    assign D_n = ~D_reg;
    always_comb begin
        carry    = '0;
        carry[0] = 1'b1;
        for (int i = 0; i < DE_W - 1; i++)
            carry[i+1] = (F_reg[i] & D_n[i]) | (carry[i] & (F_reg[i] ^ D_n[i]));
        diff = F_reg ^ D_n ^ carry;
    end

`ifdef DE_PAIR_WRAP_EN
    assign last = '1;
`else
    assign last = F_reg;
`endif

    assign D_eq_last = (D_reg == last);
    assign Do        = D_reg;
    assign Eo        = diff;

endmodule

// File: rtl/de_pair_gen.sv
// de_pair_gen top: controller FSM streaming every (D, E) pair with D+E = F,
// one pair per valid/ready handshake. Optional macro: DE_PAIR_WRAP_EN.
import de_pair_gen_pkg::*;

module de_pair_gen (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [DE_W-1:0] F,
    input  logic            ready,
    output logic [DE_W-1:0] Do,
    output logic [DE_W-1:0] Eo,
    output logic            valid,
    output logic            busy,
    output logic            done
);

    logic [1:0] state;
    logic [1:0] state_next;
    logic       F_ld;
    logic       D_clr;
    logic       D_inc;
    logic       D_eq_last;
    logic       accept;

    always_ff @(posedge clk) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    assign accept = valid & ready;

    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        F_ld       = 1'b0;
        D_clr      = 1'b0;
        D_inc      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    F_ld       = 1'b1;
                    D_clr      = 1'b1;
                    state_next = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (accept) begin
                    if (D_eq_last)
                        state_next = ST_DONE;
                    else
                        D_inc = 1'b1;
                end
            end
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign valid = (state == ST_EMIT);
    assign done  = (state == ST_DONE);
    assign busy  = valid | done;

    de_pair_gen_datapath u_datapath (
        .clk       (clk),
        .rst       (rst),
        .F         (F),
        .F_ld      (F_ld),
        .D_clr     (D_clr),
        .D_inc     (D_inc),
        .Do        (Do),
        .Eo        (Eo),
        .D_eq_last (D_eq_last)
    );

endmodule

// File: tb/tb_de_pair_gen.sv
// Scoreboard bench for de_pair_gen: a driver queues the pairs the arithmetic
// says each run must produce; a negedge monitor pops one per handshake.
module tb_de_pair_gen;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] F = 4'd0;
    logic       ready = 1'b0;
    logic [3:0] Do;
    logic [3:0] Eo;
    logic       valid;
    logic       busy;
    logic       done;

    typedef struct {
        logic [3:0] d;
        logic [3:0] e;
        bit         last;
    } pair_t;

    pair_t exp_q[$];
    bit    done_pending = 1'b0;
    int    tests = 0;
    int    failed = 0;

    de_pair_gen dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .F     (F),
        .ready (ready),
        .Do    (Do),
        .Eo    (Eo),
        .valid (valid),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one pair leaves the DUT on every edge that sees valid & ready.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            done_pending = 1'b0;
        end else begin
            if (done || done_pending)
                check("done_pulse", {31'd0, done}, {31'd0, done_pending});
            done_pending = 1'b0;
            if (valid && ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    failed++;
                    $display("FAIL extra_pair: got (%0d,%0d) expected none at %0t", Do, Eo, $time);
                end else begin
                    pair_t it;
                    it = exp_q.pop_front();
                    check("pair_d", {28'd0, Do}, {28'd0, it.d});
                    check("pair_e", {28'd0, Eo}, {28'd0, it.e});
                    done_pending = it.last;
                end
            end
        end
    end

    function automatic logic next_ready(input int mode, input int idx);
        case (mode)
            0:       return 1'b1;
            1:       return 1'($urandom_range(0, 1));
            default: return !(idx == 1 || idx == 2);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready high, 1: random ready, 2: ready pattern 1,0,0,1,1,1...
    // abort_at > 0: assert rst after that many accepts (ready must be high).
    task automatic run(input logic [3:0] f, input int mode, input bit noisy, input int abort_at);
        int n;
        int cyc;
        int guard;
        guard = 0;
        while (busy !== 1'b0 && guard < 50) begin
            tick();
            guard++;
        end
        check("idle_before_start", {31'd0, busy}, 32'd0);

`ifdef DE_PAIR_WRAP_EN
        n = 16;
`else
        n = int'(f) + 1;
`endif
        for (int d = 0; d < n; d++) begin
            pair_t it;
            it.d    = 4'(d);
            it.e    = 4'((int'(f) - d) & 15);
            it.last = (d == n - 1);
            exp_q.push_back(it);
        end

        start = 1'b1;
        F     = f;
        tick();
        start = 1'b0;
        F     = 4'($urandom);
        cyc   = 1;
        check("valid_latency", {31'd0, valid}, 32'd1);

        while (done !== 1'b1 && cyc < 300) begin
            if (abort_at > 0 && cyc == abort_at + 1) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                check("abort_state", {24'd0, Do, Eo}, 32'd0);
                check("abort_flags", {29'd0, valid, busy, done}, 32'd0);
                repeat (4) tick();
                return;
            end
            ready = next_ready(mode, cyc - 1);
            if (noisy) begin
                start = 1'($urandom_range(0, 1));
                F     = 4'($urandom);
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        check("done_seen", {31'd0, done}, 32'd1);
        if (mode == 0)
            check("run_cycles", 32'(cyc), 32'(n + 1));
        tick();
        check("busy_after_done", {30'd0, busy, done}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("reset_data", {24'd0, Do, Eo}, 32'd0);
            check("reset_flags", {29'd0, valid, busy, done}, 32'd0);
            tick();
        end

        run(4'd5, 0, 1'b0, 0);
        run(4'd3, 2, 1'b0, 0);
        run(4'd0, 0, 1'b0, 0);
        run(4'd7, 0, 1'b1, 0);
        run(4'd9, 0, 1'b0, 3);
        run(4'd2, 0, 1'b0, 0);
        run(4'd15, 1, 1'b1, 0);
        for (int r = 0; r < 8; r++)
            run(4'($urandom), int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);

        repeat (3) tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
